alu_op_sequencer: RTL and testbench

Sequencer for the 4-bit combinational ALU (A, B, s0/s1 select, 5-bit Out). It accepts one operation per valid/ready command and drives the ALU's operand and select inputs from registers. It holds them for a settle window, then captures the ALU's 5-bit result and decodes it into typed result fields and flags. The decoded result is returned on a valid/ready response channel. It sits between a command source (test driver or future register file/controller) and the ALU instance.

---
 rtl/alu_op_sequencer_if.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-side signals of the ALU operation sequencer.
// The sequencer uses slave; the environment (command source, consumer, ALU) uses master.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_s0;
  logic       alu_s1;
  logic [4:0] alu_out;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_op;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_lt;
  logic       rsp_eq;
  logic       rsp_gt;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_s0, alu_s1,
    input  rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_zero,
    input  rsp_lt, rsp_eq, rsp_gt, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_s0, alu_s1,
    output rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_zero,
    output rsp_lt, rsp_eq, rsp_gt, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives one operation at a time into the 4-bit combinational ALU, waits a settle
// window, then captures and decodes the ALU output onto a valid/ready response.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  // state | meaning
  // IDLE  | ALU inputs parked at 0, ready for a command
  // WAIT  | held operands on the ALU, settle counter running
  // RESP  | decoded result presented until the consumer takes it
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] hold_op;
  logic [3:0] hold_a, hold_b;
  logic       accept, capture;

  logic [3:0] dec_result;
  logic       dec_carry, dec_zero, dec_lt, dec_eq, dec_gt, dec_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      hold_op        <= '0;
      hold_a         <= '0;
      hold_b         <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_op     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_lt     <= 1'b0;
      bus.rsp_eq     <= 1'b0;
      bus.rsp_gt     <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        hold_op <= bus.cmd_op;
        hold_a  <= bus.cmd_a;
        hold_b  <= bus.cmd_b;
      end
      if (capture) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_op     <= hold_op;
        bus.rsp_result <= dec_result;
        bus.rsp_carry  <= dec_carry;
        bus.rsp_zero   <= dec_zero;
        bus.rsp_lt     <= dec_lt;
        bus.rsp_eq     <= dec_eq;
        bus.rsp_gt     <= dec_gt;
        bus.rsp_err    <= dec_err;
      end else if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    accept        = 1'b0;
    capture       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.alu_a     = hold_a;
    bus.alu_b     = hold_b;
    bus.alu_s0    = hold_op[0];
    bus.alu_s1    = hold_op[1];
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_s0    = 1'b0;
        bus.alu_s1    = 1'b0;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode only reinterprets the ALU code; nothing is recomputed from the operands.
  always_comb begin
    dec_result = bus.alu_out[3:0];
    dec_carry  = 1'b0;
    dec_zero   = 1'b0;
    dec_lt     = 1'b0;
    dec_eq     = 1'b0;
    dec_gt     = 1'b0;
    dec_err    = 1'b0;
    case (hold_op)
      OP_ADD, OP_SUB: begin
        dec_carry = bus.alu_out[4];
        dec_zero  = (bus.alu_out[3:0] == 4'd0);
      end
      OP_CMP: begin
        dec_lt  = bus.alu_out[0];
        dec_eq  = bus.alu_out[1];
        dec_gt  = bus.alu_out[2];
        dec_err = !((bus.alu_out[4:3] == 2'b00) &&
                    (bus.alu_out[2:0] == 3'b001 || bus.alu_out[2:0] == 3'b010 ||
                     bus.alu_out[2:0] == 3'b100));
      end
      OP_AND: begin
        dec_zero = (bus.alu_out[3:0] == 4'd0);
        dec_err  = bus.alu_out[4];
      end
      default: dec_err = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: two sequencers (settle 1 and 3) wired to a behavioural ALU,
// directed table, backpressure/reset/error sequences, then random ops vs a reference model.
module tb_alu_op_sequencer;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] result;
    logic       carry, zero, lt, eq, gt, err;
  } rsp_t;

  typedef struct packed {
    logic       cmd_ready;
    logic [3:0] alu_a, alu_b;
    logic       alu_s1, alu_s0;
    logic       rsp_valid;
    rsp_t       rsp;
  } obs_t;

  typedef struct packed {
    logic       cmd_valid;
    logic [1:0] op;
    logic [3:0] a, b;
    logic       rsp_ready;
  } drv_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a, b;
    rsp_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       stub_en;
  logic [4:0] stub_val;
  drv_t       drv [2];
  obs_t       obs [2];
  int         settle [2] = '{1, 3};
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus_s1 ();
  alu_op_sequencer_if bus_s3 ();

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (.clk(clk), .rst(rst), .bus(bus_s1.slave));
  alu_op_sequencer #(.SETTLE_CYCLES(3)) dut_s3 (.clk(clk), .rst(rst), .bus(bus_s3.slave));

  // Behavioural model of the 4-bit ALU the sequencer is meant to drive.
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic s1, input logic s0);
    case ({s1, s0})
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b1, a} - {1'b0, b};
      2'b10:   return {2'b00, a > b, a == b, a < b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  assign bus_s1.cmd_valid = drv[0].cmd_valid;
  assign bus_s1.cmd_op    = drv[0].op;
  assign bus_s1.cmd_a     = drv[0].a;
  assign bus_s1.cmd_b     = drv[0].b;
  assign bus_s1.rsp_ready = drv[0].rsp_ready;
  assign bus_s1.alu_out   = stub_en ? stub_val
                                    : alu(bus_s1.alu_a, bus_s1.alu_b, bus_s1.alu_s1, bus_s1.alu_s0);
  assign bus_s3.cmd_valid = drv[1].cmd_valid;
  assign bus_s3.cmd_op    = drv[1].op;
  assign bus_s3.cmd_a     = drv[1].a;
  assign bus_s3.cmd_b     = drv[1].b;
  assign bus_s3.rsp_ready = drv[1].rsp_ready;
  assign bus_s3.alu_out   = alu(bus_s3.alu_a, bus_s3.alu_b, bus_s3.alu_s1, bus_s3.alu_s0);

  assign obs[0] = {bus_s1.cmd_ready, bus_s1.alu_a, bus_s1.alu_b, bus_s1.alu_s1, bus_s1.alu_s0,
                   bus_s1.rsp_valid, bus_s1.rsp_op, bus_s1.rsp_result, bus_s1.rsp_carry,
                   bus_s1.rsp_zero, bus_s1.rsp_lt, bus_s1.rsp_eq, bus_s1.rsp_gt, bus_s1.rsp_err};
  assign obs[1] = {bus_s3.cmd_ready, bus_s3.alu_a, bus_s3.alu_b, bus_s3.alu_s1, bus_s3.alu_s0,
                   bus_s3.rsp_valid, bus_s3.rsp_op, bus_s3.rsp_result, bus_s3.rsp_carry,
                   bus_s3.rsp_zero, bus_s3.rsp_lt, bus_s3.rsp_eq, bus_s3.rsp_gt, bus_s3.rsp_err};

  function automatic rsp_t mk(input logic [1:0] op, input logic [3:0] res, input logic c,
                              input logic z, input logic lt, input logic eq, input logic gt,
                              input logic err);
    mk = {op, res, c, z, lt, eq, gt, err};
  endfunction

  // Expected response from operand values and the operation's arithmetic meaning.
  function automatic rsp_t ref_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    rsp_t r;
    int   s;
    r    = '0;
    r.op = op;
    case (op)
      OP_ADD: begin
        s        = int'(a) + int'(b);
        r.result = 4'(s % 16);
        r.carry  = (s > 15);
        r.zero   = (s % 16 == 0);
      end
      OP_SUB: begin
        s        = int'(a) - int'(b) + 16;
        r.result = 4'(s % 16);
        r.carry  = (a >= b);
        r.zero   = (a == b);
      end
      OP_CMP: begin
        r.lt     = (a < b);
        r.eq     = (a == b);
        r.gt     = (a > b);
        r.result = {1'b0, r.gt, r.eq, r.lt};
      end
      default: begin
        r.result = a & b;
        r.zero   = ((a & b) == 4'd0);
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one command, wait for the response, hold it for 'hold' cycles, then take it.
  task automatic run_op(input int d, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int hold, output rsp_t r, output int lat);
    chk("cmd_ready_idle", 32'(obs[d].cmd_ready), 32'(1));
    drv[d].op        = op;
    drv[d].a         = a;
    drv[d].b         = b;
    drv[d].rsp_ready = (hold == 0);
    drv[d].cmd_valid = 1'b1;
    @(posedge clk); #1;
    drv[d].cmd_valid = 1'b0;
    chk("alu_drive", 32'({obs[d].cmd_ready, obs[d].alu_a, obs[d].alu_b, obs[d].alu_s1, obs[d].alu_s0}),
        32'({1'b0, a, b, op}));
    lat = 0;
    while (!obs[d].rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = obs[d].rsp;
    if (!obs[d].rsp_valid) begin
      chk("rsp_timeout", 32'(0), 32'(1));
      drv[d].rsp_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk("hold_stable", 32'({obs[d].rsp_valid, obs[d].rsp}), 32'({1'b1, r}));
      drv[d].rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_release", 32'({obs[d].rsp_valid, obs[d].cmd_ready}), 32'(2'b01));
  endtask

  initial begin
    vec_t       vecs [9];
    rsp_t       r;
    rsp_t       exp;
    obs_t       e;
    int         lat;
    int         d;
    logic       ok;
    logic [1:0] op;
    logic [3:0] a, b;

    vecs[0] = '{OP_ADD, 4'd9,  4'd8,  mk(OP_ADD, 4'b0001, 1, 0, 0, 0, 0, 0)};
    vecs[1] = '{OP_ADD, 4'd8,  4'd8,  mk(OP_ADD, 4'b0000, 1, 1, 0, 0, 0, 0)};
    vecs[2] = '{OP_SUB, 4'd3,  4'd5,  mk(OP_SUB, 4'b1110, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{OP_SUB, 4'd5,  4'd5,  mk(OP_SUB, 4'b0000, 1, 1, 0, 0, 0, 0)};
    vecs[4] = '{OP_CMP, 4'd7,  4'd7,  mk(OP_CMP, 4'b0010, 0, 0, 0, 1, 0, 0)};
    vecs[5] = '{OP_CMP, 4'd2,  4'd9,  mk(OP_CMP, 4'b0001, 0, 0, 1, 0, 0, 0)};
    vecs[6] = '{OP_CMP, 4'd12, 4'd3,  mk(OP_CMP, 4'b0100, 0, 0, 0, 0, 1, 0)};
    vecs[7] = '{OP_AND, 4'hC,  4'hA,  mk(OP_AND, 4'b1000, 0, 0, 0, 0, 0, 0)};
    vecs[8] = '{OP_AND, 4'h5,  4'hA,  mk(OP_AND, 4'b0000, 0, 1, 0, 0, 0, 0)};

    drv[0]   = '0;
    drv[1]   = '0;
    stub_en  = 1'b0;
    stub_val = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    e           = '0;
    e.cmd_ready = 1'b1;
    for (int i = 0; i < 2; i++) chk("reset_state", 32'(obs[i]), 32'(e));

    for (int i = 0; i < 9; i++) begin
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, 0, r, lat);
      chk("vec_rsp", 32'(r), 32'(vecs[i].exp));
      chk("vec_latency", 32'(lat), 32'(1));
    end

    // Backpressure on the settle-3 instance: ADD 15+1, consumer stalled, next command waiting.
    drv[1] = '{cmd_valid: 1'b1, op: OP_ADD, a: 4'd15, b: 4'd1, rsp_ready: 1'b0};
    @(posedge clk); #1;
    drv[1].cmd_valid = 1'b0;
    ok  = 1'b1;
    lat = 0;
    while (!obs[1].rsp_valid && lat < 40) begin
      if (obs[1].cmd_ready) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    exp = mk(OP_ADD, 4'b0000, 1, 1, 0, 0, 0, 0);
    chk("bp_latency", 32'(lat), 32'(3));
    chk("bp_rsp", 32'(obs[1].rsp), 32'(exp));
    drv[1] = '{cmd_valid: 1'b1, op: OP_SUB, a: 4'd3, b: 4'd5, rsp_ready: 1'b0};
    repeat (4) begin
      @(posedge clk); #1;
      if (obs[1].cmd_ready || !obs[1].rsp_valid || obs[1].rsp != exp || obs[1].alu_a != 4'd15)
        ok = 1'b0;
    end
    chk("bp_hold", 32'(ok), 32'(1));
    drv[1].rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({obs[1].rsp_valid, obs[1].cmd_ready}), 32'(2'b01));
    @(posedge clk); #1;
    drv[1].cmd_valid = 1'b0;
    chk("bp_next_accept", 32'({obs[1].cmd_ready, obs[1].alu_a, obs[1].alu_b, obs[1].alu_s1, obs[1].alu_s0}),
        32'({1'b0, 4'd3, 4'd5, OP_SUB}));
    lat = 0;
    while (!obs[1].rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_latency", 32'(lat), 32'(3));
    chk("bp_next_rsp", 32'(obs[1].rsp), 32'(mk(OP_SUB, 4'b1110, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;

    // Reset while the settle-3 instance is in WAIT abandons the operation.
    drv[1] = '{cmd_valid: 1'b1, op: OP_ADD, a: 4'd9, b: 4'd8, rsp_ready: 1'b1};
    @(posedge clk); #1;
    drv[1].cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_idle", 32'({obs[1].cmd_ready, obs[1].rsp_valid, obs[1].alu_a, obs[1].alu_b,
                         obs[1].alu_s1, obs[1].alu_s0}), 32'({1'b1, 1'b0, 10'd0}));
    ok = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (obs[1].rsp_valid) ok = 1'b1;
    end
    chk("rst_no_rsp", 32'(ok), 32'(0));

    // Inconsistent ALU codes from a stub.
    stub_en  = 1'b1;
    stub_val = 5'b00011;
    run_op(0, OP_CMP, 4'd2, 4'd3, 0, r, lat);
    chk("err_cmp", 32'(r), 32'(mk(OP_CMP, 4'b0011, 0, 0, 1, 1, 0, 1)));
    stub_val = 5'b10000;
    run_op(0, OP_AND, 4'd15, 4'd0, 0, r, lat);
    chk("err_and", 32'(r), 32'(mk(OP_AND, 4'b0000, 0, 1, 0, 0, 0, 1)));
    stub_en = 1'b0;

    for (int n = 0; n < 300; n++) begin
      d  = n % 2;
      op = 2'($urandom_range(0, 3));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      run_op(d, op, a, b, int'($urandom_range(0, 3)), r, lat);
      chk("rand_rsp", 32'(r), 32'(ref_model(op, a, b)));
      chk("rand_latency", 32'(lat), 32'(settle[d]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
